// File: rtl/sim_mem_pkg.sv
// Shared types and helpers for the simulation AXI4 memory model:
// response codes, FSM state enums, the buffered read-request record
// and the address-to-word-index mapping.
package sim_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest address/ID a request record can carry; narrower buses are zero-extended.
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_ID_W   = 16;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_ID_W-1:0]   id;
    logic [2:0]            size;
    logic [7:0]            len;
  } req_t;

  // Byte address -> backing-store word index, wrapping modulo the store depth.
  function automatic logic [REQ_ADDR_W-1:0] word_index(input logic [REQ_ADDR_W-1:0] addr,
                                                       input int unsigned lg_bytes,
                                                       input int unsigned depth);
    return (addr >> lg_bytes) & (REQ_ADDR_W'(depth) - REQ_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/sim_axi4_req_queue.sv
// Synchronous FIFO of read requests. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module sim_axi4_req_queue
  import sim_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push_i,
  input  req_t data_i,
  input  logic pop_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  req_t           mem_q [DEPTH];
  logic [PW:0]    wr_ptr_q;
  logic [PW:0]    rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

  // Entry storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end
  end

  // Read/write pointer advance on accepted push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sim_axi4_mem_model.sv
// AXI4 slave memory model: fixed-latency, in-order INCR bursts served from
// an internal word array. Reads are queued and replayed by the read FSM;
// writes are handled one burst at a time by the write FSM.
module sim_axi4_mem_model
  import sim_mem_pkg::*;
#(
  parameter int ADDR_BITS      = 34,
  parameter int DATA_BITS      = 64,
  parameter int ID_BITS        = 4,
  parameter int DEPTH_WORDS    = 4096,
  parameter int READ_LATENCY   = 4,
  parameter int AR_QUEUE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_BITS-1:0]   ar_addr,
  input  logic [ID_BITS-1:0]     ar_id,
  input  logic [2:0]             ar_size,
  input  logic [7:0]             ar_len,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [ADDR_BITS-1:0]   aw_addr,
  input  logic [ID_BITS-1:0]     aw_id,
  input  logic [2:0]             aw_size,
  input  logic [7:0]             aw_len,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_BITS-1:0]   w_data,
  input  logic [DATA_BITS/8-1:0] w_strb,
  input  logic                   w_last,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [DATA_BITS-1:0]   r_data,
  output logic [ID_BITS-1:0]     r_id,
  output logic [1:0]             r_resp,
  output logic                   r_last,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [ID_BITS-1:0]     b_id,
  output logic [1:0]             b_resp
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int LG_BYTES  = $clog2(STRB_BITS);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int CNT_W     = $clog2(READ_LATENCY + 2);
  localparam logic [2:0] SIZE_OK = 3'(LG_BYTES);
  // The pop cycle itself is one cycle of latency; a latency of 0 or 1 loads
  // the first beat at the pop edge, otherwise R_WAIT covers the remainder.
  localparam bit LAT_DIRECT = (READ_LATENCY <= 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  logic [DATA_BITS-1:0] mem_q [DEPTH_WORDS];

  // ---------------- read request queue ----------------
  req_t               ar_req;
  req_t               q_head;
  logic               q_full;
  logic               q_empty;
  logic               q_push;
  logic               q_pop;
  logic [IDX_W-1:0]   head_idx;
  logic [ID_BITS-1:0] head_id;
  logic               head_err;

  assign ar_ready = !q_full && !reset;
  assign q_push   = ar_valid && ar_ready;
  assign ar_req   = '{addr: REQ_ADDR_W'(ar_addr), id: REQ_ID_W'(ar_id), size: ar_size, len: ar_len};
  assign head_idx = IDX_W'(word_index(q_head.addr, LG_BYTES, DEPTH_WORDS));
  assign head_id  = ID_BITS'(q_head.id);
  assign head_err = (q_head.size != SIZE_OK);

  sim_axi4_req_queue #(
    .DEPTH (AR_QUEUE_DEPTH)
  ) u_ar_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (q_push),
    .data_i  (ar_req),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // ---------------- read FSM ----------------
  rstate_e            rstate_q, rstate_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic               r_load;
  logic               r_from_head;
  logic [IDX_W-1:0]   ridx_q;
  logic [7:0]         rlen_q;
  logic [7:0]         rbeat_q;
  logic [ID_BITS-1:0] rid_q;
  logic               rerr_q;
  logic [DATA_BITS-1:0] r_data_q;
  logic [ID_BITS-1:0]   r_id_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;
  logic [IDX_W-1:0]     src_idx;
  logic [7:0]           src_len;
  logic [7:0]           src_beat;
  logic [ID_BITS-1:0]   src_id;
  logic                 src_err;

  assign r_data = r_data_q;
  assign r_id   = r_id_q;
  assign r_resp = r_resp_q;
  assign r_last = r_last_q;

  // Read state register and latency counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Read next-state: pop -> wait out the latency -> stream beats -> pop again.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (!q_empty) begin
          rstate_d = LAT_DIRECT ? R_BEAT : R_WAIT;
          rcnt_d   = WAIT_INIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) rstate_d = R_BEAT;
        else              rcnt_d   = rcnt_q - CNT_W'(1);
      end
      R_BEAT: begin
        if (r_ready && r_last_q) begin
          if (!q_empty) begin
            rstate_d = LAT_DIRECT ? R_BEAT : R_WAIT;
            rcnt_d   = WAIT_INIT;
          end else begin
            rstate_d = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read outputs: r_valid, queue pop and beat-load strobes.
  always_comb begin
    r_valid     = 1'b0;
    q_pop       = 1'b0;
    r_load      = 1'b0;
    r_from_head = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (!q_empty) begin
          q_pop       = 1'b1;
          r_load      = LAT_DIRECT;
          r_from_head = LAT_DIRECT;
        end
      end
      R_WAIT: r_load = (rcnt_q == '0);
      R_BEAT: begin
        r_valid = 1'b1;
        if (r_ready) begin
          if (!r_last_q) begin
            r_load = 1'b1;
          end else if (!q_empty) begin
            q_pop       = 1'b1;
            r_load      = LAT_DIRECT;
            r_from_head = LAT_DIRECT;
          end
        end
      end
      default: ;
    endcase
  end

  // Beat source: the freshly popped head when loading at the pop edge, else the burst in flight.
  always_comb begin
    src_idx  = r_from_head ? head_idx    : ridx_q;
    src_len  = r_from_head ? q_head.len  : rlen_q;
    src_beat = r_from_head ? 8'd0        : rbeat_q;
    src_id   = r_from_head ? head_id     : rid_q;
    src_err  = r_from_head ? head_err    : rerr_q;
  end

  // Read burst tracking and registered R channel; array read is before any same-edge write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ridx_q   <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rid_q    <= '0;
      rerr_q   <= 1'b0;
      r_data_q <= '0;
      r_id_q   <= '0;
      r_resp_q <= RESP_OKAY;
      r_last_q <= 1'b0;
    end else begin
      if (q_pop) begin
        ridx_q  <= head_idx;
        rlen_q  <= q_head.len;
        rbeat_q <= '0;
        rid_q   <= head_id;
        rerr_q  <= head_err;
      end
      if (r_load) begin
        r_data_q <= src_err ? '0 : mem_q[src_idx];
        r_id_q   <= src_id;
        r_resp_q <= src_err ? RESP_SLVERR : RESP_OKAY;
        r_last_q <= (src_beat == src_len);
        ridx_q   <= src_idx + IDX_W'(1);
        rbeat_q  <= src_beat + 8'd1;
      end
    end
  end

  // ---------------- write FSM ----------------
  wstate_e            wstate_q, wstate_d;
  logic               aw_fire;
  logic               w_fire;
  logic [IDX_W-1:0]   widx_q;
  logic [7:0]         wlen_q;
  logic [7:0]         wcnt_q;
  logic               werr_q;
  logic               wover_q;
  logic [ID_BITS-1:0] b_id_q;
  logic [1:0]         b_resp_q;

  assign aw_fire = aw_valid && aw_ready;
  assign w_fire  = w_valid && w_ready;
  assign b_id    = b_id_q;
  assign b_resp  = b_resp_q;

  // Write state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wstate_q <= W_IDLE;
    else       wstate_q <= wstate_d;
  end

  // Write next-state: address, data beats until w_last, then response.
  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE:  if (aw_fire)          wstate_d = W_DATA;
      W_DATA:  if (w_fire && w_last) wstate_d = W_RESP;
      W_RESP:  if (b_ready)          wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write outputs: handshake readies and B valid per state.
  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    unique case (wstate_q)
      W_IDLE:  aw_ready = !reset;
      W_DATA:  w_ready  = 1'b1;
      W_RESP:  b_valid  = 1'b1;
      default: ;
    endcase
  end

  // Write burst tracking; beats past len+1 or an early w_last turn the response into SLVERR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
      wover_q  <= 1'b0;
      b_id_q   <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        widx_q  <= IDX_W'(word_index(REQ_ADDR_W'(aw_addr), LG_BYTES, DEPTH_WORDS));
        wlen_q  <= aw_len;
        wcnt_q  <= '0;
        werr_q  <= (aw_size != SIZE_OK);
        wover_q <= 1'b0;
        b_id_q  <= aw_id;
      end
      if (w_fire) begin
        widx_q <= widx_q + IDX_W'(1);
        wcnt_q <= wcnt_q + 8'd1;
        if ((wcnt_q == wlen_q) && !w_last) wover_q <= 1'b1;
        if (w_last) begin
          b_resp_q <= (werr_q || wover_q || (wcnt_q != wlen_q)) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-lane array update; never reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_fire && !werr_q) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (w_strb[b]) mem_q[widx_q][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sim_axi4_mem_model.sv
// Directed bench for sim_axi4_mem_model: write/read round trip, byte strobes,
// read queue back-pressure, index wrap, size and beat-count errors, and
// asynchronous reset in the middle of a read burst.
module tb_sim_axi4_mem_model;

  logic        clock = 1'b0;
  logic        reset;
  logic        ar_valid, ar_ready;
  logic [33:0] ar_addr;
  logic [3:0]  ar_id;
  logic [2:0]  ar_size;
  logic [7:0]  ar_len;
  logic        aw_valid, aw_ready;
  logic [33:0] aw_addr;
  logic [3:0]  aw_id;
  logic [2:0]  aw_size;
  logic [7:0]  aw_len;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  sim_axi4_mem_model dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_size(ar_size), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_size(aw_size), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [63:0] wr_dat [16];
  logic [7:0]  wr_stb [16];
  int          b_lat;
  logic [3:0]  b_id_s;
  logic [1:0]  b_rsp_s;

  logic [63:0] rd_dat [16];
  logic [1:0]  rd_rsp [16];
  logic        rd_lst [16];
  logic [3:0]  rd_id_s;
  int          rd_n;
  int          rd_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one AW, then nbeats W beats (w_last on the final one), then take the B response.
  task automatic w_burst(input logic [33:0] addr, input logic [3:0] id, input logic [2:0] size,
                         input logic [7:0] len, input int nbeats);
    int g;
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_size = size; aw_len = len;
    g = 0;
    while (!aw_ready && g < 20) begin @(negedge clock); g++; end
    chk("aw_accept", 64'(aw_ready), 64'd1);
    @(negedge clock);
    aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      w_valid = 1'b1; w_data = wr_dat[i]; w_strb = wr_stb[i]; w_last = (i == nbeats - 1);
      g = 0;
      while (!w_ready && g < 20) begin @(negedge clock); g++; end
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_lat = 0;
    while (!b_valid && b_lat < 20) begin @(negedge clock); b_lat++; end
    b_id_s = b_id; b_rsp_s = b_resp;
    @(negedge clock);
  endtask

  // Present one AR and hold it until accepted; returns in the cycle after the handshake.
  task automatic ar_issue(input logic [33:0] addr, input logic [3:0] id, input logic [2:0] size,
                          input logic [7:0] len);
    int g;
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_size = size; ar_len = len;
    g = 0;
    while (!ar_ready && g < 20) begin @(negedge clock); g++; end
    chk("ar_accept", 64'(ar_ready), 64'd1);
    @(negedge clock);
    ar_valid = 1'b0;
  endtask

  // Collect one R burst; rd_lat counts cycles from the handshake cycle T to the first beat.
  task automatic r_collect();
    int guard;
    rd_lat = 1;
    while (!r_valid && rd_lat < 40) begin @(negedge clock); rd_lat++; end
    rd_n = 0;
    guard = 0;
    while (r_valid && rd_n < 16 && guard < 100) begin
      rd_dat[rd_n] = r_data; rd_rsp[rd_n] = r_resp; rd_lst[rd_n] = r_last; rd_id_s = r_id;
      rd_n++;
      guard++;
      @(negedge clock);
      if (rd_lst[rd_n-1]) break;
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    ar_valid = 0; ar_addr = '0; ar_id = '0; ar_size = '0; ar_len = '0;
    aw_valid = 0; aw_addr = '0; aw_id = '0; aw_size = '0; aw_len = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0;
    r_ready = 1'b1; b_ready = 1'b1;

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_w_ready",  64'(w_ready),  64'd0);
    chk("rst_r_valid",  64'(r_valid),  64'd0);
    chk("rst_b_valid",  64'(b_valid),  64'd0);
    chk("rst_r_data",   r_data,        64'd0);
    reset = 1'b0;
    #1;
    chk("rel_ar_ready", 64'(ar_ready), 64'd1);
    chk("rel_aw_ready", 64'(aw_ready), 64'd1);
    @(negedge clock);

    // Single-beat write then read back
    wr_dat[0] = 64'hDEADBEEF_CAFEF00D; wr_stb[0] = 8'hFF;
    w_burst(34'h40, 4'd3, 3'd3, 8'd0, 1);
    chk("t1_b_lat",  64'(b_lat),   64'd0);
    chk("t1_b_id",   64'(b_id_s),  64'd3);
    chk("t1_b_resp", 64'(b_rsp_s), 64'd0);
    ar_issue(34'h40, 4'd5, 3'd3, 8'd0);
    r_collect();
    chk("t1_r_lat",  64'(rd_lat),    64'd5);
    chk("t1_r_n",    64'(rd_n),      64'd1);
    chk("t1_r_data", rd_dat[0],      64'hDEADBEEF_CAFEF00D);
    chk("t1_r_id",   64'(rd_id_s),   64'd5);
    chk("t1_r_last", 64'(rd_lst[0]), 64'd1);
    chk("t1_r_resp", 64'(rd_rsp[0]), 64'd0);

    // Partial strobe on beat 2 of a 4-beat burst (target words cleared first)
    for (int i = 0; i < 4; i++) begin wr_dat[i] = 64'd0; wr_stb[i] = 8'hFF; end
    w_burst(34'h100, 4'd1, 3'd3, 8'd3, 4);
    wr_dat[0] = 64'h11111111_11111111; wr_stb[0] = 8'hFF;
    wr_dat[1] = 64'h22222222_22222222; wr_stb[1] = 8'hFF;
    wr_dat[2] = 64'h33333333_33333333; wr_stb[2] = 8'h0F;
    wr_dat[3] = 64'h44444444_44444444; wr_stb[3] = 8'hFF;
    w_burst(34'h100, 4'd2, 3'd3, 8'd3, 4);
    chk("t2_b_resp", 64'(b_rsp_s), 64'd0);
    ar_issue(34'h100, 4'd4, 3'd3, 8'd3);
    r_collect();
    chk("t2_r_n",     64'(rd_n),      64'd4);
    chk("t2_beat0",   rd_dat[0],      64'h11111111_11111111);
    chk("t2_beat1",   rd_dat[1],      64'h22222222_22222222);
    chk("t2_beat2",   rd_dat[2],      64'h00000000_33333333);
    chk("t2_beat3",   rd_dat[3],      64'h44444444_44444444);
    chk("t2_last0",   64'(rd_lst[0]), 64'd0);
    chk("t2_last3",   64'(rd_lst[3]), 64'd1);

    // Queue back-pressure: one request is taken into service, four more fill the queue
    r_ready = 1'b0;
    for (int k = 1; k <= 5; k++) ar_issue(34'h40, 4'(k), 3'd3, 8'd0);
    chk("t3_ar_full", 64'(ar_ready), 64'd0);
    r_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      r_collect();
      chk("t3_order_id", 64'(rd_id_s), 64'(k));
      chk("t3_order_n",  64'(rd_n),    64'd1);
    end
    chk("t3_ar_free", 64'(ar_ready), 64'd1);

    // Index wrap from the last word to word 0
    wr_dat[0] = 64'hA5A5A5A5_A5A5A5A5; wr_stb[0] = 8'hFF;
    w_burst(34'h0, 4'd1, 3'd3, 8'd0, 1);
    wr_dat[0] = 64'h5A5A5A5A_5A5A5A5A; wr_stb[0] = 8'hFF;
    w_burst(34'h7FF8, 4'd1, 3'd3, 8'd0, 1);
    ar_issue(34'h7FF8, 4'd6, 3'd3, 8'd1);
    r_collect();
    chk("t4_r_n",   64'(rd_n), 64'd2);
    chk("t4_beat0", rd_dat[0], 64'h5A5A5A5A_5A5A5A5A);
    chk("t4_beat1", rd_dat[1], 64'hA5A5A5A5_A5A5A5A5);

    // Size error on read and on write
    ar_issue(34'h40, 4'd9, 3'd2, 8'd2);
    r_collect();
    chk("t5_r_n", 64'(rd_n), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_r_resp", 64'(rd_rsp[i]), 64'd2);
      chk("t5_r_data", rd_dat[i],      64'd0);
    end
    chk("t5_r_last", 64'(rd_lst[2]), 64'd1);
    wr_dat[0] = 64'h01234567_89ABCDEF; wr_stb[0] = 8'hFF;
    w_burst(34'h40, 4'd8, 3'd2, 8'd0, 1);
    chk("t5_b_resp", 64'(b_rsp_s), 64'd2);
    chk("t5_b_id",   64'(b_id_s),  64'd8);
    ar_issue(34'h40, 4'd2, 3'd3, 8'd0);
    r_collect();
    chk("t5_unchanged", rd_dat[0], 64'hDEADBEEF_CAFEF00D);

    // Beat-count error: len 1 announced, w_last on the first beat
    wr_dat[0] = 64'h77777777_77777777; wr_stb[0] = 8'hFF;
    w_burst(34'h200, 4'd6, 3'd3, 8'd1, 1);
    chk("t6_b_resp", 64'(b_rsp_s), 64'd2);
    chk("t6_b_id",   64'(b_id_s),  64'd6);

    // Reset after the second beat of a 4-beat read is presented
    ar_issue(34'h100, 4'd7, 3'd3, 8'd3);
    seen = 0;
    while (!r_valid && seen < 40) begin @(negedge clock); seen++; end
    chk("t7_beat0", r_data, 64'h11111111_11111111);
    @(negedge clock);
    chk("t7_beat1", r_data, 64'h22222222_22222222);
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_r_valid",  64'(r_valid),  64'd0);
    chk("t7_rst_r_data",   r_data,        64'd0);
    chk("t7_rst_ar_ready", 64'(ar_ready), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t7_rel_ar_ready", 64'(ar_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (r_valid || b_valid) seen++;
    end
    chk("t7_no_more_beats", 64'(seen), 64'd0);
    ar_issue(34'h40, 4'd1, 3'd3, 8'd0);
    r_collect();
    chk("t7_kept_data", rd_dat[0], 64'hDEADBEEF_CAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
